// File: rtl/disp_pkg.sv
// Shared display constants and types for the XVGA overlay path.
package disp_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int COLOR_W  = 24;
    localparam int PX_W     = 11;
    localparam int PY_W     = 10;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } plot_state_t;

    typedef struct packed {
        logic               vis;
        logic [PX_W-1:0]    px;
        logic [PY_W-1:0]    py;
        logic [COLOR_W-1:0] color;
    } obj_t;

    // Wrapped or negative upstream coordinates land outside the visible raster.
    // Such entries are kept in the list but are never drawn.
    function automatic logic on_screen(input logic [PX_W-1:0] px,
                                       input logic [PY_W-1:0] py);
        return (px < PX_W'(H_ACTIVE)) && (py < PY_W'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/dot_hit.sv
// One object slot's comparator: is the raster position inside this object's square dot?
module dot_hit
    import disp_pkg::*;
#(
    parameter int DOT_HALF = 3
) (
    input  logic [PX_W-1:0] px,
    input  logic [PY_W-1:0] py,
    input  logic [PX_W-1:0] hcount,
    input  logic [PY_W-1:0] vcount,
    input  logic            vis,
    output logic            hit
);

    localparam logic signed [11:0] HALF = 12'(DOT_HALF);

    logic signed [11:0] dx;
    logic signed [11:0] dy;

    // Signed 12-bit distances mean a dot near column 0 clips at the left edge
    // instead of wrapping around to the far right of the line.
    always_comb begin
        dx  = $signed({1'b0, hcount}) - $signed({1'b0, px});
        dy  = $signed({2'b00, vcount}) - $signed({2'b00, py});
        hit = vis && (dx >= -HALF) && (dx <= HALF) && (dy >= -HALF) && (dy <= HALF);
    end

endmodule

// File: rtl/obj_plotter.sv
// Double-buffered object list overlay: fills a back bank from a valid/ready stream,
// swaps it in at frame_start, and paints one square dot per object with 2-clock latency.
module obj_plotter
    import disp_pkg::*;
#(
    parameter int MAX_OBJ  = 8,
    parameter int DOT_HALF = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PX_W-1:0]    in_px,
    input  logic [PY_W-1:0]    in_py,
    input  logic [COLOR_W-1:0] in_color,
    input  logic               in_last,
    input  logic [PX_W-1:0]    hcount,
    input  logic [PY_W-1:0]    vcount,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               blank,
    output logic [COLOR_W-1:0] pixel_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out,
    output logic               frame_done,
    output logic               overflow
);

    localparam int CNT_W = $clog2(MAX_OBJ + 1);
    localparam int IDX_W = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;

    plot_state_t        state;
    logic [CNT_W-1:0]   wp;
    logic [CNT_W-1:0]   front_count;
    logic               front_sel;
    logic               back_sel;
    logic               frame_start;
    obj_t               bank [2][MAX_OBJ];

    logic [MAX_OBJ-1:0] hit_comb;
    logic [MAX_OBJ-1:0] hit_q;
    logic               blank_d;
    logic               hsync_d;
    logic               vsync_d;
    logic [COLOR_W-1:0] sel_color;

    assign back_sel    = ~front_sel;
    assign frame_start = (vcount == PY_W'(V_ACTIVE)) && (hcount == '0);

    // Fill/commit control: writes the back bank, then swaps banks only at
    // frame_start so the visible list never changes mid-frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            wp          <= '0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
            in_ready    <= 1'b0;
            front_sel   <= 1'b0;
            front_count <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MAX_OBJ; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        if (wp < CNT_W'(MAX_OBJ)) begin
                            bank[back_sel][wp[IDX_W-1:0]] <= '{vis:   on_screen(in_px, in_py),
                                                               px:    in_px,
                                                               py:    in_py,
                                                               color: in_color};
                            wp <= wp + CNT_W'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (in_last) begin
                            state    <= COMMIT;
                            in_ready <= 1'b0;
                        end
                    end
                end
                COMMIT: begin
                    in_ready <= 1'b0;
                    if (frame_start) begin
                        front_sel   <= back_sel;
                        front_count <= wp;
                        wp          <= '0;
                        overflow    <= 1'b0;
                        frame_done  <= 1'b1;
                        state       <= FILL;
                        in_ready    <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // One comparator per slot against the front bank; empty slots never hit.
    for (genvar i = 0; i < MAX_OBJ; i++) begin : g_slot
        localparam logic [CNT_W-1:0] IDX = CNT_W'(i);
        dot_hit #(
            .DOT_HALF(DOT_HALF)
        ) u_hit (
            .px    (bank[front_sel][i].px),
            .py    (bank[front_sel][i].py),
            .hcount(hcount),
            .vcount(vcount),
            .vis   (bank[front_sel][i].vis && (IDX < front_count)),
            .hit   (hit_comb[i])
        );
    end

    // Stage 1: register the hit vector together with the first sync/blank delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q   <= '0;
            blank_d <= 1'b1;
            hsync_d <= 1'b1;
            vsync_d <= 1'b1;
        end else begin
            hit_q   <= hit_comb;
            blank_d <= blank;
            hsync_d <= hsync;
            vsync_d <= vsync;
        end
    end

    // Priority select: scanning downward lets the lowest-index hit win overlaps.
    always_comb begin
        sel_color = '0;
        for (int i = MAX_OBJ - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                sel_color = bank[front_sel][i].color;
            end
        end
    end

    // Stage 2: final pixel, forced black during blanking, with matching sync delay.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_out <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
            blank_out <= 1'b1;
        end else begin
            pixel_out <= blank_d ? '0 : sel_color;
            hsync_out <= hsync_d;
            vsync_out <= vsync_d;
            blank_out <= blank_d;
        end
    end

endmodule

// File: tb/tb_obj_plotter.sv
// Directed self-checking bench for obj_plotter: raster position is driven directly
// rather than swept, so each probe targets a single pixel.
module tb_obj_plotter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_px;
    logic [9:0]  in_py;
    logic [23:0] in_color;
    logic        in_last;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [23:0] pixel_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blank_out;
    logic        frame_done;
    logic        overflow;

    int pass_count  = 0;
    int total_count = 0;

    obj_plotter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_px     (in_px),
        .in_py     (in_py),
        .in_color  (in_color),
        .in_last   (in_last),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync     (hsync),
        .vsync     (vsync),
        .blank     (blank),
        .pixel_out (pixel_out),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Drive one raster position and advance one clock; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input int h, input int v, input logic blk, input logic hs, input logic vs);
        hcount = 11'(h);
        vcount = 10'(v);
        blank  = blk;
        hsync  = hs;
        vsync  = vs;
        @(posedge clock);
        #1;
    endtask

    // Hold a position for two clocks so pixel_out reflects exactly that position.
    task automatic probe(input string tag, input int h, input int v, input logic blk, input logic [23:0] expected);
        applyStimulus(h, v, blk, 1'b1, 1'b1);
        applyStimulus(h, v, blk, 1'b1, 1'b1);
        checkOutput(tag, 32'(pixel_out), 32'(expected));
    endtask

    task automatic send_obj(input int px, input int py, input logic [23:0] color, input logic last);
        int waited;
        bit done;
        in_valid = 1'b1;
        in_px    = 11'(px);
        in_py    = 10'(py);
        in_color = color;
        in_last  = last;
        waited   = 0;
        done     = 1'b0;
        while (!done && waited < 20) begin
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
            waited++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_frame_start(input string tag, input logic expect_done);
        applyStimulus(0, 768, 1'b1, 1'b1, 1'b0);
        checkOutput(tag, 32'(frame_done), 32'(expect_done));
        applyStimulus(1, 768, 1'b1, 1'b1, 1'b0);
        checkOutput({tag, "_drop"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_px    = '0;
        in_py    = '0;
        in_color = '0;
        in_last  = 1'b0;
        hcount   = '0;
        vcount   = '0;
        hsync    = 1'b1;
        vsync    = 1'b1;
        blank    = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;

        // Reset values
        checkOutput("rst_pixel", 32'(pixel_out), 32'd0);
        checkOutput("rst_hsync", 32'(hsync_out), 32'd1);
        checkOutput("rst_vsync", 32'(vsync_out), 32'd1);
        checkOutput("rst_blank", 32'(blank_out), 32'd1);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("ready_after_release", 32'(in_ready), 32'd1);

        // Test 1: single dot
        send_obj(100, 200, 24'hFF0000, 1'b1);
        checkOutput("t1_ready_low_commit", 32'(in_ready), 32'd0);
        probe("t1_before_swap", 100, 200, 1'b0, 24'h000000);
        pulse_frame_start("t1_frame_done", 1'b1);
        probe("t1_center", 100, 200, 1'b0, 24'hFF0000);
        probe("t1_topleft", 97, 197, 1'b0, 24'hFF0000);
        probe("t1_botright", 103, 203, 1'b0, 24'hFF0000);
        probe("t1_left_out", 96, 200, 1'b0, 24'h000000);
        probe("t1_right_out", 104, 200, 1'b0, 24'h000000);
        probe("t1_top_out", 100, 196, 1'b0, 24'h000000);
        probe("t1_bot_out", 100, 204, 1'b0, 24'h000000);
        probe("t1_blank_forced", 100, 200, 1'b1, 24'h000000);
        probe("t1_prev_zero", 104, 200, 1'b0, 24'h000000);
        // Latency: after one clock the old pixel remains, after two the dot appears.
        applyStimulus(100, 200, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_lat1_pixel", 32'(pixel_out), 32'd0);
        checkOutput("t1_lat1_hsync", 32'(hsync_out), 32'd1);
        applyStimulus(100, 200, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_lat2_pixel", 32'(pixel_out), 32'hFF0000);
        checkOutput("t1_lat2_hsync", 32'(hsync_out), 32'd0);
        applyStimulus(100, 200, 1'b0, 1'b1, 1'b1);
        checkOutput("t1_lat3_hsync", 32'(hsync_out), 32'd1);

        // Test 2: overlapping dots, lowest index wins
        send_obj(50, 50, 24'h00FF00, 1'b0);
        send_obj(52, 52, 24'h0000FF, 1'b1);
        pulse_frame_start("t2_frame_done", 1'b1);
        probe("t2_overlap", 51, 51, 1'b0, 24'h00FF00);
        probe("t2_idx1_only", 55, 55, 1'b0, 24'h0000FF);
        probe("t2_old_gone", 100, 200, 1'b0, 24'h000000);

        // Test 3: overflow past MAX_OBJ
        for (int k = 0; k < 10; k++) begin
            send_obj(20 + 100 * k, 100, 24'(k + 1), (k == 9) ? 1'b1 : 1'b0);
            checkOutput($sformatf("t3_overflow_%0d", k), 32'(overflow), (k >= 8) ? 32'd1 : 32'd0);
        end
        probe("t3_old_kept", 51, 51, 1'b0, 24'h00FF00);
        checkOutput("t3_overflow_held", 32'(overflow), 32'd1);
        pulse_frame_start("t3_frame_done", 1'b1);
        checkOutput("t3_overflow_clear", 32'(overflow), 32'd0);
        for (int k = 0; k < 10; k++) begin
            probe($sformatf("t3_obj_%0d", k), 20 + 100 * k, 100, 1'b0, (k < 8) ? 24'(k + 1) : 24'h000000);
        end

        // Test 4: clipping and invisible entries
        send_obj(1, 300, 24'hABCDEF, 1'b0);
        send_obj(500, 1000, 24'h123456, 1'b0);
        send_obj(1030, 10, 24'h654321, 1'b1);
        pulse_frame_start("t4_frame_done", 1'b1);
        probe("t4_col0", 0, 300, 1'b0, 24'hABCDEF);
        probe("t4_col4", 4, 300, 1'b0, 24'hABCDEF);
        probe("t4_col5", 5, 300, 1'b0, 24'h000000);
        probe("t4_col1020", 1020, 300, 1'b0, 24'h000000);
        probe("t4_col1023", 1023, 300, 1'b0, 24'h000000);
        probe("t4_py1000", 500, 1000, 1'b0, 24'h000000);
        probe("t4_px1030", 1030, 10, 1'b0, 24'h000000);
        probe("t4_prev_gone", 20, 100, 1'b0, 24'h000000);

        // Test 5a: in_last held back past a frame_start
        send_obj(200, 400, 24'h111111, 1'b0);
        pulse_frame_start("t5_no_commit", 1'b0);
        probe("t5_old_persists", 0, 300, 1'b0, 24'hABCDEF);
        send_obj(204, 400, 24'h222222, 1'b1);
        pulse_frame_start("t5_frame_done", 1'b1);
        probe("t5_idx0", 200, 400, 1'b0, 24'h111111);
        probe("t5_idx1", 206, 400, 1'b0, 24'h222222);
        probe("t5_old_gone", 0, 300, 1'b0, 24'h000000);

        // Test 5b: in_last handshake coincident with frame_start
        hcount = 11'd0;
        vcount = 10'd768;
        blank  = 1'b1;
        send_obj(600, 600, 24'h333333, 1'b1);
        checkOutput("t5c_no_done", 32'(frame_done), 32'd0);
        applyStimulus(1, 768, 1'b1, 1'b1, 1'b0);
        checkOutput("t5c_no_done2", 32'(frame_done), 32'd0);
        probe("t5c_old_kept", 200, 400, 1'b0, 24'h111111);
        probe("t5c_new_hidden", 600, 600, 1'b0, 24'h000000);
        pulse_frame_start("t5c_frame_done", 1'b1);
        probe("t5c_new_shown", 600, 600, 1'b0, 24'h333333);
        probe("t5c_old_gone", 200, 400, 1'b0, 24'h000000);

        // Test 6: reset mid-fill with a list visible
        send_obj(700, 700, 24'h444444, 1'b0);
        probe("t6_visible", 600, 600, 1'b0, 24'h333333);
        reset_n = 1'b0;
        #1;
        checkOutput("t6_rst_pixel", 32'(pixel_out), 32'd0);
        checkOutput("t6_rst_blank", 32'(blank_out), 32'd1);
        checkOutput("t6_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("t6_ready_back", 32'(in_ready), 32'd1);
        probe("t6_cleared", 600, 600, 1'b0, 24'h000000);
        pulse_frame_start("t6_no_commit", 1'b0);
        probe("t6_still_clear", 600, 600, 1'b0, 24'h000000);
        send_obj(10, 10, 24'h555555, 1'b1);
        pulse_frame_start("t6_frame_done", 1'b1);
        probe("t6_new_dot", 10, 10, 1'b0, 24'h555555);
        probe("t6_partial_gone", 700, 700, 1'b0, 24'h000000);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
